jk_mod_counter: RTL and testbench
=================================

JK_MOD_COUNTER -- requirements
Module: jk_mod_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits (2..8).
REQ-002 The block SHALL have parameter MOD, default 10, giving the count modulus (2..2^WIDTH).
REQ-003 The block SHALL have port input_CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port input_RSTN, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port input_EN, input, 1 bit: count enable; high advances the count one step per clock.
REQ-006 The block SHALL have port input_UP, input, 1 bit: direction; 1 counts up, 0 counts down.
REQ-007 The block SHALL have port input_LOAD, input, 1 bit: synchronous parallel load strobe.
REQ-008 The block SHALL have port input_D, input, WIDTH bits: parallel load value.
REQ-009 The block SHALL have port output_Q, output, WIDTH bits: current count.
REQ-010 The block SHALL have port output_QL, output, WIDTH bits: bitwise complement of output_Q.
REQ-011 The block SHALL have ports output_J and output_K, output, WIDTH bits each: per-bit JK excitation producing the next state.
REQ-012 The block SHALL have port output_TC, output, 1 bit: combinational terminal-count flag.
REQ-013 The block SHALL have port output_CARRY, output, 1 bit: registered one-cycle wrap pulse.

Function
REQ-014 Next state SHALL be selected by priority: LOAD > EN > hold.
REQ-015 LOAD=1 SHALL give next = input_D when input_D < MOD, otherwise next = 0.
REQ-016 EN=1, UP=1 SHALL give next = Q+1, wrapping MOD-1 -> 0.
REQ-017 EN=1, UP=0 SHALL give next = Q-1, wrapping 0 -> MOD-1.
REQ-018 EN=0 with LOAD=0 SHALL hold Q unchanged; output_J and output_K SHALL then be all zero.
REQ-019 For every bit i, excitation SHALL be J[i] = ~Q[i] & next[i] and K[i] = Q[i] & ~next[i], combinational from the current state and inputs.
REQ-020 The state register SHALL update with the JK characteristic Q[i]+ = (J[i] & ~Q[i]) | (~K[i] & Q[i]); this equals next for every bit.
REQ-021 output_TC SHALL be 1 iff EN=1, LOAD=0, and either (UP=1 and Q=MOD-1) or (UP=0 and Q=0).
REQ-022 output_CARRY SHALL be 1 for exactly the one clock cycle following an edge at which output_TC was 1; otherwise it is 0.
REQ-023 A direction change SHALL take effect at the next edge with no skipped or repeated count.
REQ-024 LOAD asserted in the same cycle as a terminal condition SHALL suppress both TC and the following CARRY.
REQ-025 State outside 0..MOD-1 SHALL be unreachable; arithmetic SHALL be WIDTH bits with explicit wrap compare, not natural overflow.

Reset
REQ-026 While input_RSTN=0, output_Q SHALL be 0, output_QL all ones, output_CARRY 0, and the gray register (if present) 0, asynchronously.
REQ-027 Reset asserted mid-count SHALL clear state immediately; the first edge after release SHALL apply normal next-state rules from 0.
REQ-028 output_TC, output_J and output_K SHALL follow from the reset state and current inputs; e.g. UP=0 and EN=1 during reset gives TC=1.

Configuration
REQ-029 Macro JK_MOD_COUNTER_GRAY_EN SHALL control the Gray-code output.
REQ-030 With JK_MOD_COUNTER_GRAY_EN defined, the block SHALL add port output_G, WIDTH bits: a register updated to next ^ (next >> 1) on the same edge as Q, reset to 0.
REQ-031 Without JK_MOD_COUNTER_GRAY_EN, output_G and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then EN=1, UP=1 for 12 clocks (MOD=10): Q follows 1..9,0,1,2; CARRY high only in the cycle after Q=9->0.
REQ-033 Q=0, EN=1, UP=0: next Q=9, TC=1 before that edge, CARRY=1 for one cycle after it.
REQ-034 LOAD=1 with D=7 and EN=1 -> Q=7; LOAD=1 with D=12 -> Q=0; LOAD at Q=9, UP=1 -> TC=0 and no CARRY.
REQ-035 Q=5, EN=0 for 4 clocks -> Q stays 5, J=K=0; Q=3->4 up -> J=0100, K=0011.
REQ-036 input_RSTN pulsed low between edges with Q=6 -> Q=0 immediately, QL=1111; with GRAY_EN, G=0, then count 1,2,3 -> G=0001,0011,0010.

Source files
------------

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter built from per-bit JK excitation, with parallel load,
// terminal count and registered wrap pulse. Optional Gray output: JK_MOD_COUNTER_GRAY_EN.
module jk_mod_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             input_CLK,
    input  logic             input_RSTN,
    input  logic             input_EN,
    input  logic             input_UP,
    input  logic             input_LOAD,
    input  logic [WIDTH-1:0] input_D,
    output logic [WIDTH-1:0] output_Q,
    output logic [WIDTH-1:0] output_QL,
    output logic [WIDTH-1:0] output_J,
    output logic [WIDTH-1:0] output_K,
    output logic             output_TC,
    output logic             output_CARRY
`ifdef JK_MOD_COUNTER_GRAY_EN
    ,
    output logic [WIDTH-1:0] output_G
`endif
);

    // The load bound is one bit wider than the count, as the modulus may equal 2^WIDTH.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);
    localparam logic [WIDTH-1:0] LAST  = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ZERO  = '0;
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] q_p0;
    logic             carry_p0;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j_x;
    logic [WIDTH-1:0] k_x;
    logic             tc;

    function automatic logic [WIDTH-1:0] inc_wrap(input logic [WIDTH-1:0] v);
        if (v == LAST)
            return ZERO;
        return v + ONE;
    endfunction

    function automatic logic [WIDTH-1:0] dec_wrap(input logic [WIDTH-1:0] v);
        if (v == ZERO)
            return LAST;
        return v - ONE;
    endfunction

    function automatic logic [WIDTH-1:0] load_clamp(input logic [WIDTH-1:0] v);
        if ({1'b0, v} < MOD_W)
            return v;
        return ZERO;
    endfunction

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] v);
        return v ^ (v >> 1);
    endfunction

    always_comb begin
        nxt = q_p0;
        if (input_LOAD)
            nxt = load_clamp(input_D);
        else if (input_EN)
            nxt = input_UP ? inc_wrap(q_p0) : dec_wrap(q_p0);
    end

    always_comb begin
        j_x = ~q_p0 & nxt;
        k_x = q_p0 & ~nxt;
        tc  = input_EN & ~input_LOAD &
              ((input_UP & (q_p0 == LAST)) | (~input_UP & (q_p0 == ZERO)));
    end

    // State register: JK characteristic equation per bit.
    always_ff @(posedge input_CLK or negedge input_RSTN) begin
        if (!input_RSTN) begin
            q_p0     <= '0;
            carry_p0 <= 1'b0;
        end else begin
            q_p0     <= (j_x & ~q_p0) | (~k_x & q_p0);
            carry_p0 <= tc;
        end
    end

`ifdef JK_MOD_COUNTER_GRAY_EN
    logic [WIDTH-1:0] gray_p0;

    always_ff @(posedge input_CLK or negedge input_RSTN) begin
        if (!input_RSTN)
            gray_p0 <= '0;
        else
            gray_p0 <= to_gray(nxt);
    end

    assign output_G = gray_p0;
`endif

    assign output_Q     = q_p0;
    assign output_QL    = ~q_p0;
    assign output_J     = j_x;
    assign output_K     = k_x;
    assign output_TC    = tc;
    assign output_CARRY = carry_p0;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter (WIDTH=4, MOD=10), Gray checks when JK_MOD_COUNTER_GRAY_EN is set.
module tb_jk_mod_counter;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] ql;
    logic [3:0] j;
    logic [3:0] k;
    logic       tc;
    logic       carry;
`ifdef JK_MOD_COUNTER_GRAY_EN
    logic [3:0] g;
`endif

    int n_checks = 0;
    int n_err    = 0;

    jk_mod_counter #(.WIDTH(4), .MOD(10)) dut (
        .input_CLK    (clk),
        .input_RSTN   (rst_n),
        .input_EN     (en),
        .input_UP     (up),
        .input_LOAD   (ld),
        .input_D      (d),
        .output_Q     (q),
        .output_QL    (ql),
        .output_J     (j),
        .output_K     (k),
        .output_TC    (tc),
        .output_CARRY (carry)
`ifdef JK_MOD_COUNTER_GRAY_EN
        ,
        .output_G     (g)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       up;
        logic       ld;
        logic [3:0] d;
        logic       tc;     // before the edge
        logic [3:0] j;
        logic [3:0] k;
        logic [3:0] q;      // after the edge
        logic       carry;
    } vec_t;

    vec_t vt[20];

    task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic e, input logic u, input logic l, input logic [3:0] dv);
        @(negedge clk);
        en = e;
        up = u;
        ld = l;
        d  = dv;
        #1;
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] gray4(input logic [3:0] v);
        return v ^ (v >> 1);
    endfunction

    initial begin
        //              en up ld  d      tc  J        K        Q      carry
        vt[0]  = '{T, T, F, 4'd0,  F, 4'b0001, 4'b0000, 4'd1, F};
        vt[1]  = '{T, T, F, 4'd0,  F, 4'b0010, 4'b0001, 4'd2, F};
        vt[2]  = '{T, T, F, 4'd0,  F, 4'b0001, 4'b0000, 4'd3, F};
        vt[3]  = '{T, T, F, 4'd0,  F, 4'b0100, 4'b0011, 4'd4, F};
        vt[4]  = '{T, T, T, 4'd7,  F, 4'b0011, 4'b0000, 4'd7, F};
        vt[5]  = '{T, T, F, 4'd0,  F, 4'b1000, 4'b0111, 4'd8, F};
        vt[6]  = '{T, T, F, 4'd0,  F, 4'b0001, 4'b0000, 4'd9, F};
        vt[7]  = '{T, T, F, 4'd0,  T, 4'b0000, 4'b1001, 4'd0, T};
        vt[8]  = '{F, T, F, 4'd0,  F, 4'b0000, 4'b0000, 4'd0, F};
        vt[9]  = '{T, F, F, 4'd0,  T, 4'b1001, 4'b0000, 4'd9, T};
        vt[10] = '{T, F, F, 4'd0,  F, 4'b0000, 4'b0001, 4'd8, F};
        vt[11] = '{T, T, F, 4'd0,  F, 4'b0001, 4'b0000, 4'd9, F};
        vt[12] = '{T, T, T, 4'd12, F, 4'b0000, 4'b1001, 4'd0, F};
        vt[13] = '{F, F, T, 4'd9,  F, 4'b1001, 4'b0000, 4'd9, F};
        vt[14] = '{T, T, T, 4'd3,  F, 4'b0010, 4'b1000, 4'd3, F};
        vt[15] = '{F, T, F, 4'd0,  F, 4'b0000, 4'b0000, 4'd3, F};
        vt[16] = '{F, T, T, 4'd9,  F, 4'b1000, 4'b0010, 4'd9, F};
        vt[17] = '{T, T, T, 4'd9,  F, 4'b0000, 4'b0000, 4'd9, F};
        vt[18] = '{T, T, F, 4'd0,  T, 4'b0000, 4'b1001, 4'd0, T};
        vt[19] = '{F, T, T, 4'd15, F, 4'b0000, 4'b0000, 4'd0, F};

        rst_n = 1'b0;
        en    = 1'b1;
        up    = 1'b0;
        ld    = 1'b0;
        d     = 4'd0;

        // Reset state and combinational outputs derived from it.
        #2;
        chk4("rst_q", q, 4'd0);
        chk4("rst_ql", ql, 4'b1111);
        chk1("rst_carry", carry, 1'b0);
        chk1("rst_tc_down", tc, 1'b1);
        chk4("rst_j_down", j, 4'b1001);
        chk4("rst_k_down", k, 4'b0000);
`ifdef JK_MOD_COUNTER_GRAY_EN
        chk4("rst_g", g, 4'd0);
`endif
        up = 1'b1;
        #1;
        chk1("rst_tc_up", tc, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk4("rst_hold_q", q, 4'd0);

        // Count up through a wrap: 1..9,0,1,2 with CARRY only after 9->0.
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        up    = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            edge_settle();
            chk4($sformatf("up_seq_q[%0d]", i), q, 4'(i % 10));
            chk1($sformatf("up_seq_carry[%0d]", i), carry, (i == 10));
        end

        // Table vectors, starting from Q=0.
        drive(T, T, T, 4'd0);
        edge_settle();
        chk4("tbl_start_q", q, 4'd0);
        for (int i = 0; i < 20; i++) begin
            drive(vt[i].en, vt[i].up, vt[i].ld, vt[i].d);
            chk1($sformatf("vec%0d_tc", i), tc, vt[i].tc);
            chk4($sformatf("vec%0d_j", i), j, vt[i].j);
            chk4($sformatf("vec%0d_k", i), k, vt[i].k);
            edge_settle();
            chk4($sformatf("vec%0d_q", i), q, vt[i].q);
            chk4($sformatf("vec%0d_ql", i), ql, ~vt[i].q);
            chk1($sformatf("vec%0d_carry", i), carry, vt[i].carry);
`ifdef JK_MOD_COUNTER_GRAY_EN
            chk4($sformatf("vec%0d_g", i), g, gray4(vt[i].q));
`endif
        end

        // Hold at 5 for four clocks, then 3->4 excitation.
        drive(F, T, T, 4'd5);
        edge_settle();
        for (int i = 0; i < 4; i++) begin
            drive(F, T, F, 4'd0);
            chk4($sformatf("hold_j[%0d]", i), j, 4'b0000);
            chk4($sformatf("hold_k[%0d]", i), k, 4'b0000);
            edge_settle();
            chk4($sformatf("hold_q[%0d]", i), q, 4'd5);
        end
        drive(F, T, T, 4'd3);
        edge_settle();
        drive(T, T, F, 4'd0);
        chk4("q3to4_j", j, 4'b0100);
        chk4("q3to4_k", k, 4'b0011);
        edge_settle();
        chk4("q3to4_q", q, 4'd4);

        // Down wrap from 0: CARRY lasts one cycle only.
        drive(F, T, T, 4'd0);
        edge_settle();
        drive(T, F, F, 4'd0);
        chk1("down_wrap_tc", tc, 1'b1);
        edge_settle();
        chk4("down_wrap_q", q, 4'd9);
        chk1("down_wrap_carry", carry, 1'b1);
        edge_settle();
        chk4("down_next_q", q, 4'd8);
        chk1("down_carry_drop", carry, 1'b0);

        // Asynchronous reset pulse between edges while Q=6.
        drive(F, T, T, 4'd6);
        edge_settle();
        chk4("pre_pulse_q", q, 4'd6);
        @(negedge clk);
        en    = 1'b1;
        up    = 1'b1;
        ld    = 1'b0;
        rst_n = 1'b0;
        #1;
        chk4("pulse_q", q, 4'd0);
        chk4("pulse_ql", ql, 4'b1111);
`ifdef JK_MOD_COUNTER_GRAY_EN
        chk4("pulse_g", g, 4'd0);
`endif
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            edge_settle();
            chk4($sformatf("post_rst_q[%0d]", i), q, 4'(i));
`ifdef JK_MOD_COUNTER_GRAY_EN
            chk4($sformatf("post_rst_g[%0d]", i), g, (i == 1) ? 4'b0001 : (i == 2) ? 4'b0011 : 4'b0010);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
